// File: rtl/isa_encoder.sv
// Front-panel instruction entry: builds 16-bit words from switches,
// one field per debounced button press, and offers them via valid/ready.
module isa_encoder #(
  parameter int          ADDR_W     = 8,
  parameter int          DB_CYCLES  = 50000,
  parameter logic [3:0]  IMM_OPCODE = 4'b0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        sw,
  input  logic              btn,
  input  logic              clr,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              imm_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wrapped,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_RD   = 2'd1,
    S_LO   = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]        r_sync;
  logic              r_db;
  logic              r_db_d;
  logic [CW-1:0]     r_cnt;
  logic              r_press;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wrapped;

  logic              w_hs;
  logic              w_cap_op;
  logic              w_cap_rd;
  logic              w_cap_lo;
  logic              w_take;

  // A level change is accepted only after DB_CYCLES unbroken cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn};
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
      if (r_sync[1] != r_db) begin
        if (r_cnt == DB_LAST) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_hs = r_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OP;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_cap_op = 1'b0;
    w_cap_rd = 1'b0;
    w_cap_lo = 1'b0;
    w_take   = 1'b0;
    if (clr) begin
      w_next = S_OP;
    end else begin
      unique case (r_state)
        S_OP: if (r_press) begin
          w_cap_op = 1'b1;
          w_next   = S_RD;
        end
        S_RD: if (r_press) begin
          w_cap_rd = 1'b1;
          w_next   = S_LO;
        end
        S_LO: if (r_press) begin
          w_cap_lo = 1'b1;
          w_next   = S_EMIT;
        end
        S_EMIT: if (w_hs) begin
          w_take = 1'b1;
          w_next = S_OP;
        end
      endcase
    end
  end

  // clr wins over capture and handshake, so wr_addr never moves on clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_wrapped <= 1'b0;
    end else if (clr) begin
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_cap_op) r_instr[15:12] <= sw[3:0];
      if (w_cap_rd) r_instr[11:8]  <= sw[3:0];
      if (w_cap_lo) begin
        r_instr[7:0] <= sw;
        r_valid      <= 1'b1;
      end
      if (w_take) begin
        r_valid <= 1'b0;
        r_addr  <= r_addr + ADDR_W'(1);
        if (&r_addr) r_wrapped <= 1'b1;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign imm_en      = (r_instr[15:12] == IMM_OPCODE);
  assign wr_addr     = r_addr;
  assign wrapped     = r_wrapped;
  assign state       = r_state;

endmodule
